// File: rtl/he_frame_sink.sv
// he_frame_sink: terminates the equalized pixel stream and writes it in raster order into the frame buffer.
// Define SINK_BINARIZE_EN to write (pixel > BIN_THRESH) ? 8'hFF : 8'h00 instead of the raw pixel.
module he_frame_sink #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int ADDR_W     = 18,
    parameter int BIN_THRESH = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   pix_cnt,
    output logic              err_sync
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    if (((64'd1 << ADDR_W) < (64'(IMG_WIDTH) * 64'(IMG_HEIGHT))) || (BIN_THRESH < 0) || (BIN_THRESH > 255)) begin : g_bad_cfg
        $error("he_frame_sink: ADDR_W too small for the frame or BIN_THRESH outside 0..255");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t             state, state_next;
    logic [XW-1:0]      x, eff_x;
    logic [YW-1:0]      y, eff_y;
    logic [ADDR_W-1:0]  lin, eff_lin;
    logic               wr_pend;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               last_accepted;
    logic               enter_capture;
    logic               accept, commit, final_commit;
    logic               at_origin, sof_resync, frame_err, is_last;
    logic [7:0]         pixel_out;

`ifdef SINK_BINARIZE_EN
    assign pixel_out = (s_data > 8'(BIN_THRESH)) ? 8'hFF : 8'h00;
`else
    assign pixel_out = s_data;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        enter_capture = 1'b0;
        busy          = 1'b0;
        s_ready       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = CAPTURE;
                    enter_capture = 1'b1;
                end
            end
            CAPTURE: begin
                busy    = 1'b1;
                s_ready = !last_accepted && (!wr_pend || mem_ack);
                if (last_accepted && wr_pend && mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next    = CAPTURE;
                    enter_capture = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An SOF away from the origin snaps the raster position back to (0,0) for this pixel.
    always_comb begin
        at_origin    = (x == '0) && (y == '0);
        sof_resync   = s_sof && !at_origin;
        eff_x        = sof_resync ? '0 : x;
        eff_y        = sof_resync ? '0 : y;
        eff_lin      = sof_resync ? '0 : lin;
        is_last      = (eff_x == X_LAST) && (eff_y == Y_LAST);
        frame_err    = (s_sof != at_origin) || (s_eol != (eff_x == X_LAST));
        accept       = s_valid && s_ready;
        commit       = wr_pend && mem_ack;
        final_commit = (state == CAPTURE) && last_accepted && commit;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x             <= '0;
            y             <= '0;
            lin           <= '0;
            pix_cnt       <= '0;
            err_sync      <= 1'b0;
            last_accepted <= 1'b0;
            frame_done    <= 1'b0;
            wr_pend       <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            frame_done <= final_commit;
            if (enter_capture) begin
                x             <= '0;
                y             <= '0;
                lin           <= '0;
                pix_cnt       <= '0;
                err_sync      <= 1'b0;
                last_accepted <= 1'b0;
            end else begin
                if (commit) begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
                if (accept) begin
                    if (sof_resync) begin
                        pix_cnt <= '0;
                    end
                    if (frame_err) begin
                        err_sync <= 1'b1;
                    end
                    if (eff_x == X_LAST) begin
                        x <= '0;
                        y <= eff_y + 1'b1;
                    end else begin
                        x <= eff_x + 1'b1;
                        y <= eff_y;
                    end
                    lin           <= eff_lin + 1'b1;
                    last_accepted <= is_last;
                end
            end
            // A new accept overwrites the register in the same edge its predecessor is acked.
            if (accept) begin
                wr_pend <= 1'b1;
                wr_addr <= eff_lin;
                wr_data <= pixel_out;
            end else if (commit) begin
                wr_pend <= 1'b0;
            end
        end
    end

    assign mem_we    = wr_pend;
    assign mem_addr  = wr_addr;
    assign mem_wdata = wr_data;

endmodule

// File: tb/tb_he_frame_sink.sv
// tb_he_frame_sink: drives he_frame_sink on a 4x2 frame and checks every cycle against a
// raster-index reference model (linear pixel position, queue of outstanding writes).
module tb_he_frame_sink;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int AW   = 3;
    localparam int BT   = 0;
    localparam int NPIX = W * H;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_sof;
    logic          s_eol;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic          busy;
    logic          frame_done;
    logic [AW:0]   pix_cnt;
    logic          err_sync;

    typedef struct {
        bit         last;
        int         addr;
        logic [7:0] data;
    } exp_wr_t;

    exp_wr_t    m_q[$];
    bit         m_capturing, m_full, m_err, m_done;
    int         m_pos, m_cnt;
    int         checks, errors, dut_done, frames_exp;
    logic [7:0] px_data[32];
    logic       px_sof[32];
    logic       px_eol[32];

    he_frame_sink #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW),
        .BIN_THRESH(BT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .frame_done(frame_done),
        .pix_cnt   (pix_cnt),
        .err_sync  (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] shape(input logic [7:0] d);
`ifdef SINK_BINARIZE_EN
        return (d > 8'(BT)) ? 8'hFF : 8'h00;
`else
        return d;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd0);
        checkOutput({tag, "_err_sync"}, 32'(err_sync), 32'd0);
    endtask

    task automatic modelReset();
        m_q.delete();
        m_capturing = 0;
        m_full      = 0;
        m_err       = 0;
        m_done      = 0;
        m_pos       = 0;
        m_cnt       = 0;
    endtask

    // Reference rule set applied to one accepted pixel, in linear-index terms.
    task automatic modelAccept(input logic [7:0] d, input logic sof, input logic eol);
        exp_wr_t w;
        if (sof != (m_pos == 0)) m_err = 1;
        if (sof && m_pos != 0) begin
            m_pos = 0;
            m_cnt = 0;
        end
        if (eol != ((m_pos % W) == W - 1)) m_err = 1;
        w.last = (m_pos == NPIX - 1);
        w.addr = m_pos;
        w.data = shape(d);
        m_q.push_back(w);
        if (w.last) m_full = 1;
        m_pos++;
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic sof, input logic eol,
                        input logic ack, input logic st, output logic acc);
        logic    rdy_exp, we_exp, commit, start_ok, done_next;
        exp_wr_t head;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        mem_ack = ack;
        start   = st;
        #1;
        we_exp  = (m_q.size() != 0);
        rdy_exp = m_capturing && !m_full && (!we_exp || ack);
        checkOutput("s_ready", 32'(s_ready), 32'(rdy_exp));
        checkOutput("mem_we", 32'(mem_we), 32'(we_exp));
        if (we_exp) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(m_q[0].addr));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_q[0].data));
        end
        checkOutput("busy", 32'(busy), 32'(m_capturing));
        checkOutput("frame_done", 32'(frame_done), 32'(m_done));
        checkOutput("err_sync", 32'(err_sync), 32'(m_err));
        checkOutput("pix_cnt", 32'(pix_cnt), 32'(m_cnt));
        if (frame_done === 1'b1) dut_done++;
        acc       = v && rdy_exp;
        commit    = we_exp && ack;
        start_ok  = st && !m_capturing;
        done_next = 0;
        if (commit) begin
            head = m_q.pop_front();
            m_cnt++;
            if (head.last) begin
                m_capturing = 0;
                done_next   = 1;
            end
        end
        if (acc) modelAccept(d, sof, eol);
        if (start_ok) begin
            m_capturing = 1;
            m_full      = 0;
            m_err       = 0;
            m_pos       = 0;
            m_cnt       = 0;
        end
        m_done = done_next;
    endtask

    task automatic fillFrame(input int n);
        for (int i = 0; i < n; i++) begin
            px_data[i] = 8'($urandom_range(0, 255));
            px_sof[i]  = ((i % NPIX) == 0);
            px_eol[i]  = ((i % W) == W - 1);
        end
    endtask

    // ack_mode: 0 always, 1 three-cycle stall on address 2, 2 random; valid_mode: 0 steady, 2 random with stray starts.
    task automatic applyStimulus(input int n, input int ack_mode, input int valid_mode);
        int   idx, cyc, stalls;
        logic v, ack, st, acc;
        idx    = 0;
        cyc    = 0;
        stalls = 0;
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        while ((idx < n || m_capturing) && cyc < 400) begin
            v = (idx < n) && (valid_mode == 0 || $urandom_range(0, 2) != 0);
            case (ack_mode)
                1:       ack = !(m_q.size() != 0 && m_q[0].addr == 2 && stalls < 3);
                2:       ack = ($urandom_range(0, 3) != 0);
                default: ack = 1'b1;
            endcase
            if (!ack && ack_mode == 1) stalls++;
            st = (valid_mode != 0) && ($urandom_range(0, 15) == 0);
            tick(v, px_data[idx], px_sof[idx], px_eol[idx], ack, st, acc);
            if (acc) idx++;
            cyc++;
        end
        if (cyc >= 400) begin
            checks++;
            errors++;
            $error("[TB] FAIL drain_budget observed=%0d accepted expected=%0d", idx, n);
        end
        frames_exp++;
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("frame_done_pulses", 32'(dut_done), 32'(frames_exp));
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        logic acc;
        int   idx;
        checks     = 0;
        errors     = 0;
        dut_done   = 0;
        frames_exp = 0;
        modelReset();
        rstn    = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        mem_ack = 1'b0;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] idle: pixels must not be accepted before start");
        tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0, acc);

        $display("[TB] clean frame, continuous valid and ack");
        fillFrame(NPIX);
        applyStimulus(NPIX, 0, 0);
        checkOutput("clean_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        checkOutput("clean_err_sync", 32'(err_sync), 32'd0);

        $display("[TB] clean frame, three-cycle stall on pixel 2");
        fillFrame(NPIX);
        applyStimulus(NPIX, 1, 0);
        checkOutput("stall_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        checkOutput("stall_err_sync", 32'(err_sync), 32'd0);

        $display("[TB] SOF on pixel 5 forces resync");
        fillFrame(13);
        for (int i = 5; i < 13; i++) begin
            px_sof[i] = (i == 5);
            px_eol[i] = (((i - 5) % W) == W - 1);
        end
        applyStimulus(13, 0, 0);
        checkOutput("resync_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        checkOutput("resync_err_sync", 32'(err_sync), 32'd1);

        $display("[TB] missing EOL at end of first row");
        fillFrame(NPIX);
        px_eol[3] = 1'b0;
        applyStimulus(NPIX, 0, 0);
        checkOutput("eol_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        checkOutput("eol_err_sync", 32'(err_sync), 32'd1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 4; f++) begin
            fillFrame(NPIX);
            for (int i = 0; i < NPIX; i++) begin
                if ($urandom_range(0, 7) == 0) px_eol[i] = !px_eol[i];
            end
            if ($urandom_range(0, 3) == 0) px_sof[0] = 1'b0;
            applyStimulus(NPIX, 2, 2);
            checkOutput("rand_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        end

        $display("[TB] reset mid-frame with a write pending");
        fillFrame(NPIX);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            tick(1'b1, px_data[idx], px_sof[idx], px_eol[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        #1;
        checkOutput("midrst_we_before", 32'(mem_we), 32'd1);
        rstn = 1'b0;
        #1;
        checkResetValues("midrst");
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
        fillFrame(NPIX);
        applyStimulus(NPIX, 0, 0);
        checkOutput("postrst_pix_cnt", 32'(pix_cnt), 32'(NPIX));
        checkOutput("postrst_err_sync", 32'(err_sync), 32'd0);

`ifdef SINK_BINARIZE_EN
        $display("[TB] binarized writes");
        fillFrame(NPIX);
        px_data[0] = 8'h00;
        px_data[1] = 8'h01;
        px_data[2] = 8'h80;
        px_data[3] = 8'h00;
        applyStimulus(NPIX, 0, 0);
        checkOutput("bin_pix_cnt", 32'(pix_cnt), 32'(NPIX));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/he_frame_sink.md
# he_frame_sink

Stream-to-memory sink that terminates the output side of the histogram-equalization pixel stream. It accepts one 8-bit pixel per valid/ready handshake, tracks raster position, and writes each pixel into a frame buffer through a single-port write interface with back-pressure. It flags framing errors and signals completion after exactly IMG_WIDTH × IMG_HEIGHT pixels have been committed. It sits between the equalization core output and the frame buffer that the dump/readback path drains.

## Interface
- IMG_WIDTH, 512, pixels per row
- IMG_HEIGHT, 512, rows per frame
- ADDR_W, 18, frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_WIDTH × IMG_HEIGHT
- BIN_THRESH, 0, binarization threshold; used only when the Configuration feature is compiled in
- clk  in  1  rising-edge clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle pulse that arms capture of one frame
- s_valid  in  1  pixel valid
- s_ready  out  1  sink can accept the pixel this cycle
- s_data  in  8  pixel value
- s_sof  in  1  marks the first pixel of a frame; qualified by s_valid
- s_eol  in  1  marks the last pixel of a row; qualified by s_valid
- mem_we  out  1  write request to the frame buffer
- mem_addr  out  ADDR_W  write address, y*IMG_WIDTH + x
- mem_wdata  out  8  write data
- mem_ack  in  1  frame buffer accepted the write this cycle
- busy  out  1  high in the CAPTURE state
- frame_done  out  1  one-cycle pulse when the final write is acknowledged
- pix_cnt  out  ADDR_W+1  pixels committed to memory in the current frame
- err_sync  out  1  sticky framing-error flag; cleared by start or reset

## Operation
- The FSM has three states: IDLE, CAPTURE and DONE. On reset it enters IDLE.
- IDLE → CAPTURE on start. Entering CAPTURE clears x, y, pix_cnt and err_sync.
- CAPTURE → DONE when the write for pixel IMG_WIDTH×IMG_HEIGHT−1 is acknowledged. DONE → CAPTURE on start. A start pulse in CAPTURE is ignored.
- A pixel is accepted when s_valid && s_ready. The accepted pixel is loaded into a one-entry write register (wr_pend, addr, data), and x/y advance in raster order.
- x wraps from IMG_WIDTH−1 to 0 and increments y. After the last pixel no further pixels are accepted.
- Pixels presented outside CAPTURE are not accepted, because s_ready is low.
- Framing checks are applied to each accepted pixel and each sets err_sync:
  - s_sof with (x,y) ≠ (0,0): counters resynchronize and this pixel is written at address 0. pix_cnt resets to 0 before counting this pixel.
  - Missing s_sof at (0,0): the pixel is still written; counters do not change behaviour.
  - s_eol when x ≠ IMG_WIDTH−1, or no s_eol when x = IMG_WIDTH−1: counters advance normally; no resync.
- pix_cnt increments on every mem_we && mem_ack.
- mem_wdata equals the accepted s_data, except when the Configuration feature is compiled in.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, pix_cnt=0, err_sync=0.
- s_ready = (state==CAPTURE) && !last_accepted && (!wr_pend || mem_ack). This allows one accept per cycle under continuous mem_ack.
- Latency: a pixel accepted at edge N drives mem_we/mem_addr/mem_wdata from edge N until the edge where mem_ack is sampled high.
- mem_we, mem_addr and mem_wdata are held stable while mem_ack is low.
- Simultaneous accept and ack on the same edge: the write register is replaced with the new pixel, with no bubble.
- frame_done is asserted in the cycle after the final ack, as the FSM enters DONE.
- Reset mid-frame discards any pending write immediately; mem_we drops asynchronously.

## Configuration
- SINK_BINARIZE_EN defined: mem_wdata = (pixel > BIN_THRESH) ? 8'hFF : 8'h00. With the default threshold 0, any nonzero pixel becomes FF.
- SINK_BINARIZE_EN undefined: mem_wdata = pixel unmodified, and BIN_THRESH is unused.

## Test plan
- 4×2 frame, s_valid and mem_ack held high, data 0..7 with correct sof/eol → addresses 0..7 written with data 0..7 on consecutive cycles; frame_done pulses once; pix_cnt=8; err_sync=0.
- Same frame with mem_ack low for 3 cycles on pixel 2 → s_ready low during the stall; mem_addr=2 and mem_wdata=2 held stable; no pixel lost or duplicated.
- s_sof asserted on pixel 5 → err_sync=1; that pixel is written at address 0; the frame completes 8 pixels later.
- s_eol omitted at x=3 → err_sync=1; the next pixel is still written at address 4.
- Reset mid-frame after 3 pixels, then start → all outputs return to their reset values; the new frame begins at address 0 with pix_cnt=0.
- With SINK_BINARIZE_EN, pixels {0,1,0x80,0} → writes {00,FF,FF,00}.
